// File: rtl/regbank_write_arbiter_if.sv
// Write-port bundle between the two requesters (A = ALU, B = load unit),
// the arbiter and the dff register bank.
// Ports: req/addr/data per requester in, gnt per requester out;
//        bank_d, reg_load to the bank; busy, err status.
interface regbank_write_arbiter_if #(
    parameter int WIDTH  = 8,
    parameter int NREGS  = 8,
    parameter int ADDR_W = 3
);
    logic              req_a;
    logic [ADDR_W-1:0] addr_a;
    logic [WIDTH-1:0]  data_a;
    logic              gnt_a;
    logic              req_b;
    logic [ADDR_W-1:0] addr_b;
    logic [WIDTH-1:0]  data_b;
    logic              gnt_b;
    logic [WIDTH-1:0]  bank_d;
    logic [NREGS-1:0]  reg_load;
    logic              busy;
    logic              err;

    modport master (
        output req_a, addr_a, data_a,
        output req_b, addr_b, data_b,
        input  gnt_a, gnt_b,
        input  bank_d, reg_load, busy, err
    );

    modport slave (
        input  req_a, addr_a, data_a,
        input  req_b, addr_b, data_b,
        output gnt_a, gnt_b,
        output bank_d, reg_load, busy, err
    );
endinterface

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter for the single write port of the register bank.
// Ports: clk, rst_n (sync, active-low); wr = slave side of the write bundle.
module regbank_write_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NREGS   = 8,
    parameter int ADDR_W  = 3,
    parameter int ZERO_RO = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    regbank_write_arbiter_if.slave  wr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_COMMIT
    } state_t;

    state_t            state_q, state_d;
    logic              win_q, win_d;
    logic              ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  bank_d_q, bank_d_d;
    logic              gnt_a_q, gnt_a_d;
    logic              gnt_b_q, gnt_b_d;
    logic              err_q, err_d;
    logic [NREGS-1:0]  load_q, load_d;

    logic pick_b;
    logic win_req;
    logic addr_oob;
    logic addr_ro;

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        ptr_d    = ptr_q;
        addr_d   = addr_q;
        bank_d_d = bank_d_q;
        gnt_a_d  = 1'b0;
        gnt_b_d  = 1'b0;
        err_d    = 1'b0;
        load_d   = '0;

        // win/ptr: 0 = A, 1 = B
        pick_b   = wr.req_b & (~wr.req_a | ptr_q);
        win_req  = win_q ? wr.req_b : wr.req_a;
        addr_oob = (int'(addr_q) >= NREGS);
        addr_ro  = (ZERO_RO != 0) && (addr_q == '0);

        unique case (state_q)
            S_IDLE: begin
                if (wr.req_a | wr.req_b) begin
                    state_d  = S_SETUP;
                    win_d    = pick_b;
                    addr_d   = pick_b ? wr.addr_b : wr.addr_a;
                    bank_d_d = pick_b ? wr.data_b : wr.data_a;
                end
            end
            S_SETUP: begin
                if (win_req) begin
                    state_d = S_COMMIT;
                    gnt_a_d = ~win_q;
                    gnt_b_d = win_q;
                    err_d   = addr_oob;
                    if (!addr_oob && !addr_ro) begin
                        for (int i = 0; i < NREGS; i++) begin
                            load_d[i] = (int'(addr_q) == i);
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COMMIT: begin
                ptr_d   = ~win_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            win_q    <= 1'b0;
            ptr_q    <= 1'b0;
            addr_q   <= '0;
            bank_d_q <= '0;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            err_q    <= 1'b0;
            load_q   <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            ptr_q    <= ptr_d;
            addr_q   <= addr_d;
            bank_d_q <= bank_d_d;
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
            err_q    <= err_d;
            load_q   <= load_d;
        end
    end

    // The bank captures at the edge that ends COMMIT; a reset sampled at
    // that same edge must kill the load and the handshake, so the pulses
    // are qualified with rst_n.
    assign wr.gnt_a    = gnt_a_q & rst_n;
    assign wr.gnt_b    = gnt_b_q & rst_n;
    assign wr.err      = err_q & rst_n;
    assign wr.reg_load = load_q & {NREGS{rst_n}};
    assign wr.bank_d   = bank_d_q;
    assign wr.busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Self-checking bench for regbank_write_arbiter.
// Directed scenarios plus randomized traffic against a transaction model.
module tb_regbank_write_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    regbank_write_arbiter_if #(.WIDTH(8), .NREGS(8), .ADDR_W(3)) ifc ();
    regbank_write_arbiter_if #(.WIDTH(8), .NREGS(6), .ADDR_W(3)) ifc6 ();

    regbank_write_arbiter #(
        .WIDTH(8), .NREGS(8), .ADDR_W(3), .ZERO_RO(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .wr(ifc)
    );

    regbank_write_arbiter #(
        .WIDTH(8), .NREGS(6), .ADDR_W(3), .ZERO_RO(1)
    ) u_dut6 (
        .clk(clk), .rst_n(rst_n), .wr(ifc6)
    );

    // Behavioural dff bank fed by the 8-register arbiter.
    logic [7:0] bank [8] = '{default: 8'h00};
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++)
            if (ifc.reg_load[i]) bank[i] <= ifc.bank_d;
    end

    task automatic idle_inputs();
        ifc.req_a = 0; ifc.addr_a = 0; ifc.data_a = 0;
        ifc.req_b = 0; ifc.addr_b = 0; ifc.data_b = 0;
        ifc6.req_a = 0; ifc6.addr_a = 0; ifc6.data_a = 0;
        ifc6.req_b = 0; ifc6.addr_b = 0; ifc6.data_b = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.req_a = 1; ifc.addr_a = 3'd1; ifc.data_a = 8'h5A;
        repeat (2) begin
            @(negedge clk);
            total++;
            if ({ifc.gnt_a, ifc.gnt_b, ifc.busy, ifc.err,
                 ifc.reg_load, ifc.bank_d} !== 20'h0) begin
                bad++;
                $display("FAIL reset_outs: got gnt=%b%b busy=%b err=%b load=%h d=%h want all 0",
                         ifc.gnt_a, ifc.gnt_b, ifc.busy, ifc.err,
                         ifc.reg_load, ifc.bank_d);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (ifc.busy !== 1'b1 || ifc.gnt_a !== 1'b0 || ifc.bank_d !== 8'h5A) begin
            bad++;
            $display("FAIL reset_setup: got busy=%b gnt=%b d=%h want 1 0 5a",
                     ifc.busy, ifc.gnt_a, ifc.bank_d);
        end
        @(negedge clk);
        total++;
        if (ifc.gnt_a !== 1'b1 || ifc.reg_load !== 8'b0000_0010) begin
            bad++;
            $display("FAIL reset_commit: got gnt=%b load=%b want 1 00000010",
                     ifc.gnt_a, ifc.reg_load);
        end
        ifc.req_a = 0;
        @(negedge clk);
        total++;
        if (ifc.busy !== 1'b0 || bank[1] !== 8'h5A) begin
            bad++;
            $display("FAIL reset_after: got busy=%b reg1=%h want 0 5a",
                     ifc.busy, bank[1]);
        end
    endtask

    task automatic test_single_write();
        ifc.req_a = 1; ifc.addr_a = 3'd3; ifc.data_a = 8'hA5;
        @(negedge clk);
        total++;
        if (ifc.bank_d !== 8'hA5 || ifc.reg_load !== 8'h00 || ifc.gnt_a !== 1'b0) begin
            bad++;
            $display("FAIL single_setup: got d=%h load=%b gnt=%b want a5 0 0",
                     ifc.bank_d, ifc.reg_load, ifc.gnt_a);
        end
        @(negedge clk);
        total++;
        if (ifc.bank_d !== 8'hA5 || ifc.reg_load !== 8'b0000_1000 || ifc.gnt_a !== 1'b1) begin
            bad++;
            $display("FAIL single_commit: got d=%h load=%b gnt=%b want a5 00001000 1",
                     ifc.bank_d, ifc.reg_load, ifc.gnt_a);
        end
        ifc.req_a = 0;
        @(negedge clk);
        total++;
        if (bank[3] !== 8'hA5) begin
            bad++;
            $display("FAIL single_bank: got reg3=%h want a5", bank[3]);
        end
    endtask

    task automatic test_alternate();
        bit ea, eb;
        do_reset();
        ifc.req_a = 1; ifc.addr_a = 3'd1; ifc.data_a = 8'h11;
        ifc.req_b = 1; ifc.addr_b = 3'd2; ifc.data_b = 8'h22;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            ea = (c % 3 == 2) && ((c / 3) % 2 == 0);
            eb = (c % 3 == 2) && ((c / 3) % 2 == 1);
            total++;
            if (ifc.gnt_a !== ea || ifc.gnt_b !== eb) begin
                bad++;
                $display("FAIL alt_gnt c=%0d: got a=%b b=%b want a=%b b=%b",
                         c, ifc.gnt_a, ifc.gnt_b, ea, eb);
            end
        end
        ifc.req_a = 0; ifc.req_b = 0;
        @(negedge clk);
        total++;
        if (bank[1] !== 8'h11 || bank[2] !== 8'h22 || ifc.busy !== 1'b0) begin
            bad++;
            $display("FAIL alt_bank: got reg1=%h reg2=%h busy=%b want 11 22 0",
                     bank[1], bank[2], ifc.busy);
        end
    endtask

    task automatic test_abort();
        do_reset();
        ifc.req_b = 1; ifc.addr_b = 3'd5; ifc.data_b = 8'h55;
        @(negedge clk);
        total++;
        if (ifc.busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_setup: got busy=%b want 1", ifc.busy);
        end
        ifc.req_b = 0;
        @(negedge clk);
        total++;
        if (ifc.busy !== 1'b0 || ifc.gnt_b !== 1'b0 || ifc.reg_load !== 8'h00) begin
            bad++;
            $display("FAIL abort_idle: got busy=%b gnt_b=%b load=%b want 0 0 0",
                     ifc.busy, ifc.gnt_b, ifc.reg_load);
        end
        ifc.req_a = 1; ifc.addr_a = 3'd6; ifc.data_a = 8'h66;
        ifc.req_b = 1; ifc.addr_b = 3'd7; ifc.data_b = 8'h77;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (ifc.gnt_a !== 1'b1 || ifc.gnt_b !== 1'b0) begin
            bad++;
            $display("FAIL abort_ptr: got a=%b b=%b want a=1 b=0",
                     ifc.gnt_a, ifc.gnt_b);
        end
        ifc.req_a = 0; ifc.req_b = 0;
        @(negedge clk);
        total++;
        if (bank[5] !== 8'h00 || bank[6] !== 8'h66) begin
            bad++;
            $display("FAIL abort_bank: got reg5=%h reg6=%h want 00 66",
                     bank[5], bank[6]);
        end
    endtask

    task automatic test_dropped();
        ifc.req_a = 1; ifc.addr_a = 3'd0; ifc.data_a = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (ifc.gnt_a !== 1'b1 || ifc.reg_load !== 8'h00 || ifc.err !== 1'b0) begin
            bad++;
            $display("FAIL drop_zero: got gnt=%b load=%b err=%b want 1 0 0",
                     ifc.gnt_a, ifc.reg_load, ifc.err);
        end
        ifc.req_a = 0;
        @(negedge clk);
        total++;
        if (bank[0] !== 8'h00) begin
            bad++;
            $display("FAIL drop_reg0: got reg0=%h want 00", bank[0]);
        end
        ifc6.req_a = 1; ifc6.addr_a = 3'd7; ifc6.data_a = 8'h12;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (ifc6.gnt_a !== 1'b1 || ifc6.err !== 1'b1 || ifc6.reg_load !== 6'h00) begin
            bad++;
            $display("FAIL drop_oob: got gnt=%b err=%b load=%b want 1 1 0",
                     ifc6.gnt_a, ifc6.err, ifc6.reg_load);
        end
        ifc6.req_a = 0;
        @(negedge clk);
        total++;
        if (ifc6.err !== 1'b0 || ifc6.gnt_a !== 1'b0) begin
            bad++;
            $display("FAIL drop_pulse: got err=%b gnt=%b want 0 0",
                     ifc6.err, ifc6.gnt_a);
        end
    endtask

    task automatic test_reset_commit();
        ifc.req_a = 1; ifc.addr_a = 3'd4; ifc.data_a = 8'h33;
        @(negedge clk);
        @(negedge clk);
        ifc.req_a = 0;
        @(negedge clk);
        ifc.req_a = 1; ifc.addr_a = 3'd4; ifc.data_a = 8'h77;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (ifc.gnt_a !== 1'b1) begin
            bad++;
            $display("FAIL rstc_commit: got gnt=%b want 1", ifc.gnt_a);
        end
        rst_n = 1'b0;
        ifc.req_a = 0;
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if (ifc.busy !== 1'b0 || ifc.reg_load !== 8'h00 || ifc.gnt_a !== 1'b0) begin
            bad++;
            $display("FAIL rstc_idle: got busy=%b load=%b gnt=%b want 0 0 0",
                     ifc.busy, ifc.reg_load, ifc.gnt_a);
        end
        total++;
        if (bank[4] !== 8'h33) begin
            bad++;
            $display("FAIL rstc_bank: got reg4=%h want 33", bank[4]);
        end
        ifc.req_a = 1; ifc.addr_a = 3'd1; ifc.data_a = 8'hAA;
        ifc.req_b = 1; ifc.addr_b = 3'd2; ifc.data_b = 8'hBB;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (ifc.gnt_a !== 1'b1 || ifc.gnt_b !== 1'b0) begin
            bad++;
            $display("FAIL rstc_ptr: got a=%b b=%b want a=1 b=0",
                     ifc.gnt_a, ifc.gnt_b);
        end
        ifc.req_a = 0; ifc.req_b = 0;
        @(negedge clk);
    endtask

    // Transaction model: an idle arbiter that sees requests picks the sole
    // requester, or the one not granted last; the grant shows two cycles
    // later and the port is free again one cycle after that.
    task automatic test_random();
        int free_at = 0;
        int gnt_cyc = -1;
        bit gw = 0;
        bit last = 1;
        logic [2:0] ga = 0;
        logic [7:0] gd = 0;
        logic [7:0] ref_mem [8];
        bit written [8];
        bit ea, eb, eby;
        logic [7:0] eload;
        for (int i = 0; i < 8; i++) begin
            written[i] = 0;
            ref_mem[i] = 0;
        end
        do_reset();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            ea = (gnt_cyc == k) && !gw;
            eb = (gnt_cyc == k) && gw;
            eby = (k < free_at) && (k > free_at - 3);
            total++;
            if (ifc.gnt_a !== ea || ifc.gnt_b !== eb ||
                ifc.busy !== eby || ifc.err !== 1'b0) begin
                bad++;
                $display("FAIL rnd_hs k=%0d: got a=%b b=%b busy=%b err=%b want %b %b %b 0",
                         k, ifc.gnt_a, ifc.gnt_b, ifc.busy, ifc.err, ea, eb, eby);
            end
            if (gnt_cyc == k) begin
                eload = (ga == 3'd0) ? 8'h00 : (8'h01 << ga);
                total++;
                if (ifc.reg_load !== eload || ifc.bank_d !== gd) begin
                    bad++;
                    $display("FAIL rnd_load k=%0d: got load=%b d=%h want %b %h",
                             k, ifc.reg_load, ifc.bank_d, eload, gd);
                end
                if (ga != 3'd0) begin
                    ref_mem[ga] = gd;
                    written[ga] = 1;
                end
            end else begin
                total++;
                if (ifc.reg_load !== 8'h00) begin
                    bad++;
                    $display("FAIL rnd_noload k=%0d: got load=%b want 0",
                             k, ifc.reg_load);
                end
            end
            if (ifc.gnt_a) ifc.req_a = 0;
            if (ifc.gnt_b) ifc.req_b = 0;
            if (!ifc.req_a && $urandom_range(0, 2) == 0) begin
                ifc.req_a = 1;
                ifc.addr_a = 3'($urandom_range(0, 7));
                ifc.data_a = 8'($urandom);
            end
            if (!ifc.req_b && $urandom_range(0, 2) == 0) begin
                ifc.req_b = 1;
                ifc.addr_b = 3'($urandom_range(0, 7));
                ifc.data_b = 8'($urandom);
            end
            if (k >= free_at && (ifc.req_a || ifc.req_b)) begin
                gw = ifc.req_b && (!ifc.req_a || last == 1'b0);
                ga = gw ? ifc.addr_b : ifc.addr_a;
                gd = gw ? ifc.data_b : ifc.data_a;
                gnt_cyc = k + 2;
                free_at = k + 3;
                last = gw;
            end
        end
        ifc.req_a = 0; ifc.req_b = 0;
        repeat (4) @(negedge clk);
        for (int i = 1; i < 8; i++) begin
            if (written[i]) begin
                total++;
                if (bank[i] !== ref_mem[i]) begin
                    bad++;
                    $display("FAIL rnd_bank r%0d: got %h want %h",
                             i, bank[i], ref_mem[i]);
                end
            end
        end
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_single_write();
        test_alternate();
        test_abort();
        test_dropped();
        test_reset_commit();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
